mem_access_stage: RTL

- MEM stage of the 5-stage RV32I pipeline; consumes the EX/MEM register outputs produced by the execute stage.
- Drives a req/ready data-memory port and produces the MEM/WB register, including the write-back value returned to the forwarding path.
- Generates a pipeline stall while a data access is outstanding and aborts hung accesses after a timeout.

---
 rtl/mem_access_stage.sv | 134 +++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage RV32I pipeline: drives the req/ready data-memory port, stalls upstream
// while an access is outstanding, aborts hung accesses, and produces the MEM/WB register.
// Optional build macro MEM_MISALIGN_CHECK_EN rejects word-misaligned accesses with a bus error.
module mem_access_stage #(
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [DATA_W-1:0] i_ex_mem_alu_result,
    input  logic [DATA_W-1:0] i_ex_mem_write_data,
    input  logic [4:0]        i_ex_mem_rd,
    input  logic              i_ex_mem_reg_write,
    input  logic              i_ex_mem_mem_read,
    input  logic              i_ex_mem_mem_write,
    input  logic              i_ex_mem_mem_to_reg,
    input  logic              i_dmem_ready,
    input  logic [DATA_W-1:0] i_dmem_rdata,
    output logic              o_dmem_req,
    output logic              o_dmem_we,
    output logic [DATA_W-1:0] o_dmem_addr,
    output logic [DATA_W-1:0] o_dmem_wdata,
    output logic              o_stall,
    output logic              o_bus_error,
    output logic [4:0]        o_mem_wb_rd,
    output logic              o_mem_wb_reg_write,
    output logic [DATA_W-1:0] o_mem_wb_write_data
);

    localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_bus_error;
    logic [4:0]         r_mem_wb_rd;
    logic               r_mem_wb_reg_write;
    logic [DATA_W-1:0]  r_mem_wb_write_data;

    logic               w_mem_op;
    logic               w_misalign;
    logic               w_timeout;
    logic               w_abort;
    logic               w_req;
    logic               w_stall;
    logic               w_load_data;
    logic [DATA_W-1:0]  w_wb_data;

    assign w_mem_op = i_ex_mem_mem_read | i_ex_mem_mem_write;

`ifdef MEM_MISALIGN_CHECK_EN
    assign w_misalign = w_mem_op & (i_ex_mem_alu_result[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_timeout = (r_state == S_WAIT) & ~i_dmem_ready & (r_cnt == CNT_MAX);
    assign w_abort   = w_mem_op & (w_timeout | w_misalign);

    // Reset gates the request combinationally so an in-flight access drops at once.
    assign w_req   = w_mem_op & ~w_abort & ~i_reset;
    assign w_stall = w_req & ~i_dmem_ready;

    // Only loads select memory data; a set mem_to_reg without an access keeps the ALU result.
    assign w_load_data = w_mem_op & i_ex_mem_mem_to_reg & ~i_ex_mem_mem_write;
    assign w_wb_data   = w_load_data ? i_dmem_rdata : i_ex_mem_alu_result;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_stall) begin
                        r_state <= S_WAIT;
                        r_cnt   <= CNT_W'(1);
                    end
                end
                S_WAIT: begin
                    // Leaving covers completion, timeout abort and a withdrawn access alike.
                    if (!w_stall) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_bus_error         <= 1'b0;
            r_mem_wb_rd         <= '0;
            r_mem_wb_reg_write  <= 1'b0;
            r_mem_wb_write_data <= '0;
        end else begin
            r_bus_error <= w_abort;
            if (w_stall || w_abort) begin
                // Bubble keeps the forwarding path from seeing a half-finished access.
                r_mem_wb_rd         <= '0;
                r_mem_wb_reg_write  <= 1'b0;
                r_mem_wb_write_data <= '0;
            end else begin
                r_mem_wb_rd         <= i_ex_mem_rd;
                r_mem_wb_reg_write  <= i_ex_mem_reg_write;
                r_mem_wb_write_data <= w_wb_data;
            end
        end
    end

    assign o_dmem_req          = w_req;
    assign o_dmem_we           = i_ex_mem_mem_write;
    assign o_dmem_addr         = i_ex_mem_alu_result;
    assign o_dmem_wdata        = i_ex_mem_write_data;
    assign o_stall             = w_stall;
    assign o_bus_error         = r_bus_error;
    assign o_mem_wb_rd         = r_mem_wb_rd;
    assign o_mem_wb_reg_write  = r_mem_wb_reg_write;
    assign o_mem_wb_write_data = r_mem_wb_write_data;

endmodule
